// File: rtl/stopwatch_core.sv
// stopwatch_core: prescaled stopwatch timebase with a BCD MM:SS.t count,
// run/stop toggle, clear and lap-hold display.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze and capture registers).
// Control inputs are single-cycle pulses sampled on the rising edge; there
// is no handshake, each pulse is acted on in the cycle it is high.
module stopwatch_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic       frozen,
  output logic       tick,
  output logic       wrap,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] LAST   = PW'(DIV - 1);
  localparam logic [3:0]    MT_MAX = 4'(MAX_MIN / 10);
  localparam logic [3:0]    MO_MAX = 4'(MAX_MIN % 10);

  logic [PW-1:0] r_presc;
  logic          r_running;
  logic          r_tick;
  logic          r_wrap;
  logic [3:0]    r_t, r_so, r_st, r_mo, r_mt;

  logic [PW-1:0] w_presc_nx;
  logic          w_running_nx;
  logic          w_step;
  logic          w_wrap;
  logic [3:0]    w_t, w_so, w_st, w_mo, w_mt;

  // Next prescaler, run state and BCD time; clear overrides everything.
  always_comb begin
    w_presc_nx   = r_presc;
    w_running_nx = r_running;
    w_step       = 1'b0;
    w_wrap       = 1'b0;
    w_t          = r_t;
    w_so         = r_so;
    w_st         = r_st;
    w_mo         = r_mo;
    w_mt         = r_mt;
    if (clear) begin
      w_presc_nx = '0;
      w_t        = 4'd0;
      w_so       = 4'd0;
      w_st       = 4'd0;
      w_mo       = 4'd0;
      w_mt       = 4'd0;
    end else begin
      if (start_stop) w_running_nx = ~r_running;
      if (r_running) begin
        if (r_presc == LAST) begin
          w_presc_nx = '0;
          w_step     = 1'b1;
        end else begin
          w_presc_nx = r_presc + 1'b1;
        end
      end
      if (w_step) begin
        if (r_t != 4'd9) begin
          w_t = r_t + 4'd1;
        end else begin
          w_t = 4'd0;
          if (r_so != 4'd9) begin
            w_so = r_so + 4'd1;
          end else begin
            w_so = 4'd0;
            if (r_st != 4'd5) begin
              w_st = r_st + 4'd1;
            end else begin
              w_st = 4'd0;
              if (r_mt == MT_MAX && r_mo == MO_MAX) begin
                w_mo   = 4'd0;
                w_mt   = 4'd0;
                w_wrap = 1'b1;
              end else if (r_mo == 4'd9) begin
                w_mo = 4'd0;
                w_mt = r_mt + 4'd1;
              end else begin
                w_mo = r_mo + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Count state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_t       <= 4'd0;
      r_so      <= 4'd0;
      r_st      <= 4'd0;
      r_mo      <= 4'd0;
      r_mt      <= 4'd0;
    end else begin
      r_presc   <= w_presc_nx;
      r_running <= w_running_nx;
      r_tick    <= w_step;
      r_wrap    <= w_wrap;
      r_t       <= w_t;
      r_so      <= w_so;
      r_st      <= w_st;
      r_mo      <= w_mo;
      r_mt      <= w_mt;
    end
  end

  assign running = r_running;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
  logic       r_frozen;
  logic [3:0] r_dt, r_dso, r_dst, r_dmo, r_dmt;
  logic       w_frozen_nx;
  logic       w_capture;

  // Lap toggle: capture the presented time when entering the hold.
  always_comb begin
    w_frozen_nx = r_frozen;
    w_capture   = 1'b0;
    if (clear) begin
      w_frozen_nx = 1'b0;
    end else if (lap) begin
      w_frozen_nx = ~r_frozen;
      w_capture   = ~r_frozen;
    end
  end

  // Display registers follow the next live time unless a lap is held;
  // on capture they take the pre-increment time of this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frozen <= 1'b0;
      r_dt     <= 4'd0;
      r_dso    <= 4'd0;
      r_dst    <= 4'd0;
      r_dmo    <= 4'd0;
      r_dmt    <= 4'd0;
    end else begin
      r_frozen <= w_frozen_nx;
      if (!w_frozen_nx) begin
        r_dt  <= w_t;
        r_dso <= w_so;
        r_dst <= w_st;
        r_dmo <= w_mo;
        r_dmt <= w_mt;
      end else if (w_capture) begin
        r_dt  <= r_t;
        r_dso <= r_so;
        r_dst <= r_st;
        r_dmo <= r_mo;
        r_dmt <= r_mt;
      end
    end
  end

  assign frozen   = r_frozen;
  assign tenths   = r_dt;
  assign sec_ones = r_dso;
  assign sec_tens = r_dst;
  assign min_ones = r_dmo;
  assign min_tens = r_dmt;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign frozen   = 1'b0;
  assign tenths   = r_t;
  assign sec_ones = r_so;
  assign sec_tens = r_st;
  assign min_ones = r_mo;
  assign min_tens = r_mt;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed plan plus randomized pulses, every cycle
// checked against a tenths-as-integer reference model via a queue.
module tb_stopwatch_core;

  localparam int CLK_HZ  = 50;
  localparam int TICK_HZ = 10;
  localparam int MAX_MIN = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int TOTAL   = (MAX_MIN + 1) * 600;

  logic       clk;
  logic       rst, start_stop, clear, lap;
  logic       running, frozen, tick, wrap;
  logic [3:0] tenths, sec_ones, sec_tens, min_ones, min_tens;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];

  // reference model state
  int m_run, m_frz, m_presc, m_time, m_lapv;

  stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .running(running), .frozen(frozen), .tick(tick), .wrap(wrap),
    .tenths(tenths), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens)
  );

  // clock / reset
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] pack(int run, int frz, int tk, int wr, int t);
    int mins, secs;
    mins = t / 600;
    secs = (t / 10) % 60;
    return {1'(run), 1'(frz), 1'(tk), 1'(wr), 4'(mins / 10), 4'(mins % 10),
            4'(secs / 10), 4'(secs % 10), 4'(t % 10)};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit c, input bit l,
                            output logic [23:0] e);
    int tk, wr;
    tk = 0;
    wr = 0;
    if (r) begin
      m_run = 0; m_frz = 0; m_presc = 0; m_time = 0; m_lapv = 0;
    end else if (c) begin
      m_time = 0; m_presc = 0; m_frz = 0;
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (l) begin
        if (m_frz == 0) begin
          m_lapv = m_time;
          m_frz  = 1;
        end else begin
          m_frz = 0;
        end
      end
`endif
      if (m_run != 0) begin
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          m_time  = (m_time + 1) % TOTAL;
          tk = 1;
          wr = (m_time == 0) ? 1 : 0;
        end else begin
          m_presc = m_presc + 1;
        end
      end
      if (s) m_run = (m_run != 0) ? 0 : 1;
    end
    e = pack(m_run, m_frz, tk, wr, (m_frz != 0) ? m_lapv : m_time);
  endtask

  // driver: apply one cycle of inputs and queue the expected outputs
  task automatic cyc(input bit r, input bit s, input bit c, input bit l);
    logic [23:0] e;
    @(negedge clk);
    rst = r; start_stop = s; clear = c; lap = l;
    model_step(r, s, c, l, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // wait for the edge that samples the last driven inputs
  task automatic look();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compare every registered output vector against the queue
  initial begin
    logic [23:0] got, e;
    forever begin
      @(posedge clk);
      #1;
      got = {running, frozen, tick, wrap, min_tens, min_ones, sec_tens, sec_ones, tenths};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %h with nothing expected at %0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs: got %h expected %h at %0t", got, e, $time);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    m_run = 0; m_frz = 0; m_presc = 0; m_time = 0; m_lapv = 0;

    // reset state
    repeat (3) cyc(1, 0, 0, 0);
    look();
    chk("reset_running", running, 0);
    chk("reset_tick", tick, 0);
    chk("reset_digits", {min_tens, min_ones, sec_tens, sec_ones, tenths}, 0);

    // first tick exactly DIV cycles after start
    cyc(0, 1, 0, 0);
    idle(4);
    look();
    chk("first_tick_early", tick, 0);
    idle(1);
    look();
    chk("first_tick", tick, 1);
    chk("first_tenths", tenths, 1);
    idle(45);
    look();
    chk("ten_ticks_tenths", tenths, 0);
    chk("ten_ticks_sec", sec_ones, 1);

    // stop mid-period and resume completes the partial period
    cyc(0, 0, 1, 0);
    idle(30);
    look();
    chk("six_ticks", tenths, 6);
    idle(1);
    cyc(0, 1, 0, 0);
    idle(20);
    look();
    chk("stopped_running", running, 0);
    chk("stopped_hold", tenths, 6);
    cyc(0, 1, 0, 0);
    idle(2);
    look();
    chk("resume_no_tick_yet", tick, 0);
    idle(1);
    look();
    chk("resume_tick", tick, 1);
    chk("resume_tenths", tenths, 7);

    // lap hold at 00:03.4, release at 00:05.0
    cyc(0, 0, 1, 0);
    idle(170);
    cyc(0, 0, 0, 1);
    look();
    chk("lap_sec", sec_ones, 3);
    chk("lap_tenths", tenths, 4);
`ifdef STOPWATCH_LAP_EN
    chk("lap_frozen", frozen, 1);
`else
    chk("lap_frozen_off", frozen, 0);
`endif
    idle(79);
    look();
`ifdef STOPWATCH_LAP_EN
    chk("lap_held_sec", sec_ones, 3);
`else
    chk("live_sec", sec_ones, 5);
`endif
    cyc(0, 0, 0, 1);
    look();
    chk("lap_release_frozen", frozen, 0);
    chk("lap_release_sec", sec_ones, 5);
    chk("lap_release_tenths", tenths, 0);

    // clear on a tick boundary at 00:02.9
    cyc(0, 0, 1, 0);
    idle(149);
    cyc(0, 0, 1, 0);
    look();
    chk("clr_bound_tick", tick, 0);
    chk("clr_bound_digits", {min_tens, min_ones, sec_tens, sec_ones, tenths}, 0);
    chk("clr_bound_running", running, 1);
    idle(4);
    look();
    chk("clr_next_early", tick, 0);
    idle(1);
    look();
    chk("clr_next_tick", tick, 1);

    // reset while running and frozen at 00:07.2
    cyc(0, 0, 1, 0);
    idle(360);
    cyc(0, 0, 0, 1);
    idle(2);
    cyc(1, 0, 0, 0);
    look();
    chk("rst_running", running, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_tick", tick, 0);
    chk("rst_digits", {min_tens, min_ones, sec_tens, sec_ones, tenths}, 0);

    // rollover from 01:59.9
    cyc(0, 1, 0, 0);
    idle(5995);
    look();
    chk("pre_wrap_digits", {min_tens, min_ones, sec_tens, sec_ones, tenths}, 20'h01599);
    idle(5);
    look();
    chk("wrap_pulse", wrap, 1);
    chk("wrap_tick", tick, 1);
    chk("wrap_digits", {min_tens, min_ones, sec_tens, sec_ones, tenths}, 0);

    // randomized pulses
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 149) == 0), ($urandom_range(0, 29) == 0));
    end
    idle(2);

    // drain
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
